// File: rtl/reaction_timer_core.sv
// Reaction timer core.
// Measures the time between a randomly delayed lamp and the player's button press.
// Flow: IDLE -> WAIT (random delay) -> REACT (lamp on, counting ms) -> DONE.
// A press during WAIT is a false start and goes to FAULT.
// Elapsed time is kept directly in BCD so it can drive a display without conversion.
// The best (smallest) valid result is kept until reset.
module reaction_timer_core #(
  parameter int TICK_DIV     = 100000,
  parameter int DIGITS       = 4,
  parameter int MIN_DELAY_MS = 1000,
  parameter int DLY_BITS     = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn,
  input  logic                  clear,
  output logic [2:0]            state,
  output logic                  led_on,
  output logic [4*DIGITS-1:0]   bcd_time,
  output logic [4*DIGITS-1:0]   best_time,
  output logic                  result_valid,
  output logic                  false_start,
  output logic                  timeout
);

  localparam int BW = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(MIN_DELAY_MS + (1 << DLY_BITS) + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_REACT = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t          state_q;
  logic [15:0]     lfsr_q;
  logic            lfsr_fb;
  logic [PW-1:0]   presc_q;
  logic            tick;
  logic [DW-1:0]   delay_q;
  logic [BW-1:0]   bcd_q;
  logic [BW-1:0]   best_q;
  logic [BW-1:0]   bcd_next;
  logic            all_nines;
  logic            carry;
  logic [3:0]      digit;

  assign state     = state_q;
  assign bcd_time  = bcd_q;
  assign best_time = best_q;

  // Feedback for the taps 16,14,13,11; a nonzero seed keeps the register out of the all-zero lock-up state.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // The prescaler's terminal count marks the end of one millisecond.
  assign tick = (presc_q == PW'(TICK_DIV - 1));

  // Free-running random source, untouched by clear so successive games get different delays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'h0001;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  // BCD increment with ripple decimal carry, and all-9s detection for saturation.
  always_comb begin
    bcd_next  = bcd_q;
    all_nines = 1'b1;
    carry     = 1'b1;
    digit     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = bcd_q[4*i +: 4];
      if (digit != 4'd9) begin
        all_nines = 1'b0;
      end
      if (carry) begin
        if (digit == 4'd9) begin
          bcd_next[4*i +: 4] = 4'd0;
        end else begin
          bcd_next[4*i +: 4] = digit + 4'd1;
          carry              = 1'b0;
        end
      end
    end
  end

  // Main game FSM; it also owns the prescaler, which restarts whenever a timed phase begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      delay_q      <= '0;
      bcd_q        <= '0;
      best_q       <= {DIGITS{4'h9}};
      led_on       <= 1'b0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      presc_q      <= tick ? '0 : presc_q + PW'(1);

      if (clear) begin
        state_q     <= S_IDLE;
        bcd_q       <= '0;
        led_on      <= 1'b0;
        false_start <= 1'b0;
        timeout     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (btn) begin
              state_q <= S_WAIT;
              delay_q <= DW'(MIN_DELAY_MS) + DW'(lfsr_q[DLY_BITS-1:0]);
              presc_q <= '0;
            end
          end

          S_WAIT: begin
            if (btn) begin
              state_q     <= S_FAULT;
              false_start <= 1'b1;
              led_on      <= 1'b0;
            end else if (tick) begin
              if (delay_q <= DW'(1)) begin
                state_q <= S_REACT;
                led_on  <= 1'b1;
                bcd_q   <= '0;
                presc_q <= '0;
              end else begin
                delay_q <= delay_q - DW'(1);
              end
            end
          end

          S_REACT: begin
            if (btn) begin
              state_q      <= S_DONE;
              result_valid <= 1'b1;
              if (bcd_q < best_q) begin
                best_q <= bcd_q;
              end
            end else if (tick) begin
              if (all_nines) begin
                state_q <= S_DONE;
                timeout <= 1'b1;
              end else begin
                bcd_q <= bcd_next;
              end
            end
          end

          S_DONE, S_FAULT: begin
            if (btn) begin
              state_q     <= S_IDLE;
              led_on      <= 1'b0;
              timeout     <= 1'b0;
              false_start <= 1'b0;
            end
          end

          default: begin
            state_q     <= S_IDLE;
            led_on      <= 1'b0;
            timeout     <= 1'b0;
            false_start <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
